// File: rtl/pcint_group_ctrl.sv
// Pin-change interrupt group: pad synchroniser, masked edge detect, PCIFn flag and PCMSKn register.
// Optional macro PCINT_WAKE_EN adds a combinational pad-to-wake path that works with cp2 stopped.
module pcint_group_ctrl #(
  parameter int              WIDTH         = 4,
  parameter logic [7:0]      PCMSK_ADDRESS = 8'h73,
  parameter logic [5:0]      PCIFR_ADDRESS = 6'h1B,
  parameter int              PCIF_BIT      = 3
) (
  input  logic             cp2,
  input  logic             ireset,
  input  logic [5:0]       IO_Addr,
  input  logic             iore,
  input  logic             iowe,
  input  logic [7:0]       ramadr,
  input  logic             ramre,
  input  logic             ramwe,
  input  logic [7:0]       dbus_in,
  output logic [7:0]       dbus_out,
  output logic             out_en,
  input  logic [WIDTH-1:0] pin_i,
  input  logic             pcie_i,
  input  logic             SLEEP,
  input  logic             irqack,
  output logic [WIDTH-1:0] pcmsk_o,
  output logic             irq_o,
  output logic             wake_o
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] pcmsk_q, pcmsk_d;
  logic             pcif_q, pcif_d;

  logic [WIDTH-1:0] edge_vec;
  logic             chg;
  logic             pcifr_sel;
  logic             pcmsk_sel;
  logic             pcifr_w1c;
  logic [7:0]       unused_dbus;

  assign unused_dbus = dbus_in;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign edge_vec[gi] = (sync2_q[gi] ^ prev_q[gi]) & pcmsk_q[gi];
    end
  endgenerate

  assign chg       = (|edge_vec) & pcie_i;
  assign pcifr_sel = (IO_Addr == PCIFR_ADDRESS);
  assign pcmsk_sel = (ramadr == PCMSK_ADDRESS);
  assign pcifr_w1c = iowe & pcifr_sel & dbus_in[PCIF_BIT];

  always_comb begin
    sync1_d = pin_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pcmsk_d = pcmsk_q;
    pcif_d  = pcif_q;
    if (ramwe && pcmsk_sel) begin
      pcmsk_d = dbus_in[WIDTH-1:0];
    end
    if (pcifr_w1c || irqack) begin
      pcif_d = 1'b0;
    end
    // A detected edge overrides any clear in the same cycle so no edge is lost.
    if (chg) begin
      pcif_d = 1'b1;
    end
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pcmsk_q <= '0;
      pcif_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pcmsk_q <= pcmsk_d;
      pcif_q  <= pcif_d;
    end
  end

  // Only our own PCIFn bit is driven; the bus ORs in the other groups.
  always_comb begin
    dbus_out = 8'h00;
    out_en   = 1'b0;
    if (iore && pcifr_sel) begin
      out_en             = 1'b1;
      dbus_out[PCIF_BIT] = pcif_q;
    end
    if (ramre && pcmsk_sel) begin
      out_en   = 1'b1;
      dbus_out = dbus_out | 8'(pcmsk_q);
    end
  end

  assign pcmsk_o = pcmsk_q;
  assign irq_o   = pcif_q & pcie_i;

`ifdef PCINT_WAKE_EN
  assign wake_o = SLEEP & pcie_i & (|((pin_i ^ prev_q) & pcmsk_q));
`else
  logic unused_sleep;
  assign unused_sleep = SLEEP;
  assign wake_o       = 1'b0;
`endif

endmodule

// File: tb/tb_pcint_group_ctrl.sv
// Directed self-checking bench for pcint_group_ctrl with hand-computed expectations.
module tb_pcint_group_ctrl;

  logic       cp2;
  logic       ireset;
  logic [5:0] IO_Addr;
  logic       iore;
  logic       iowe;
  logic [7:0] ramadr;
  logic       ramre;
  logic       ramwe;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       out_en;
  logic [3:0] pin_i;
  logic       pcie_i;
  logic       SLEEP;
  logic       irqack;
  logic [3:0] pcmsk_o;
  logic       irq_o;
  logic       wake_o;

  logic clk_en;
  int   checks;
  int   failures;

  pcint_group_ctrl dut (
    .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
    .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .out_en(out_en), .pin_i(pin_i), .pcie_i(pcie_i),
    .SLEEP(SLEEP), .irqack(irqack), .pcmsk_o(pcmsk_o), .irq_o(irq_o), .wake_o(wake_o)
  );

  initial cp2 = 1'b0;
  always begin
    #5;
    if (clk_en) cp2 = ~cp2;
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("pass %s value=%0h", tag, got);
    end
  endtask

  task automatic mask_write(input logic [7:0] data);
    @(negedge cp2);
    ramadr = 8'h73; dbus_in = data; ramwe = 1'b1;
    @(negedge cp2);
    ramwe = 1'b0; dbus_in = 8'h00;
    $display("wr PCMSK <= %02h", data);
  endtask

  task automatic pcifr_write(input logic [7:0] data);
    @(negedge cp2);
    IO_Addr = 6'h1B; dbus_in = data; iowe = 1'b1;
    @(negedge cp2);
    iowe = 1'b0; dbus_in = 8'h00;
    $display("wr PCIFR <= %02h", data);
  endtask

  task automatic read_pcmsk(input string tag, input logic [7:0] exp);
    ramadr = 8'h73; ramre = 1'b1;
    #1;
    check_value({tag, "_data"}, 32'(dbus_out), 32'(exp));
    check_value({tag, "_en"}, 32'(out_en), 32'd1);
    ramre = 1'b0;
  endtask

  task automatic read_pcifr(input string tag, input logic [7:0] exp);
    IO_Addr = 6'h1B; iore = 1'b1;
    #1;
    check_value({tag, "_data"}, 32'(dbus_out), 32'(exp));
    check_value({tag, "_en"}, 32'(out_en), 32'd1);
    iore = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0; clk_en = 1'b1;
    ireset = 1'b0; IO_Addr = '0; iore = 0; iowe = 0; ramadr = '0; ramre = 0; ramwe = 0;
    dbus_in = '0; pin_i = '0; pcie_i = 0; SLEEP = 0; irqack = 0;

    // Reset state
    repeat (3) @(negedge cp2);
    #1;
    check_value("rst_irq", 32'(irq_o), 0);
    check_value("rst_wake", 32'(wake_o), 0);
    check_value("rst_out_en", 32'(out_en), 0);
    check_value("rst_dbus", 32'(dbus_out), 0);
    check_value("rst_pcmsk", 32'(pcmsk_o), 0);
    @(negedge cp2);
    ireset = 1'b1;

    // Basic detect with two-edge latency
    pcie_i = 1'b1;
    mask_write(8'h04);
    check_value("mask_o", 32'(pcmsk_o), 32'h4);
    read_pcmsk("rd_mask", 8'h04);
    @(negedge cp2);
    pin_i = 4'b0100;
    @(negedge cp2); #1;
    check_value("lat_n", 32'(irq_o), 0);
    @(negedge cp2); #1;
    check_value("lat_n1", 32'(irq_o), 0);
    @(negedge cp2); #1;
    check_value("lat_n2", 32'(irq_o), 1);
    read_pcifr("rd_pcifr_set", 8'h08);

    // Write-one-to-clear semantics
    pcifr_write(8'h00);
    #1; check_value("w1c_zero", 32'(irq_o), 1);
    pcifr_write(8'h08);
    #1; check_value("w1c_one", 32'(irq_o), 0);
    read_pcifr("rd_pcifr_clr", 8'h00);

    // Unmasked toggles leave no stale history behind
    mask_write(8'h00);
    pin_i = 4'b0000; repeat (3) @(negedge cp2);
    pin_i = 4'b0100; repeat (3) @(negedge cp2);
    pin_i = 4'b0000; repeat (3) @(negedge cp2);
    #1; check_value("nomask_toggle", 32'(irq_o), 0);
    mask_write(8'h04);
    repeat (4) @(negedge cp2);
    #1; check_value("mask_enable", 32'(irq_o), 0);
    pin_i = 4'b0010; repeat (4) @(negedge cp2);
    #1; check_value("other_pin", 32'(irq_o), 0);

    // Set wins over simultaneous W1C
    pin_i = 4'b0110; repeat (3) @(negedge cp2);
    #1; check_value("pre_coinc", 32'(irq_o), 1);
    pin_i = 4'b0010;
    @(negedge cp2);
    @(negedge cp2);
    IO_Addr = 6'h1B; dbus_in = 8'h08; iowe = 1'b1;
    @(negedge cp2);
    iowe = 1'b0; dbus_in = 8'h00;
    #1; check_value("coinc_w1c", 32'(irq_o), 1);
    pcifr_write(8'h08);
    #1; check_value("after_w1c", 32'(irq_o), 0);

    // Set wins over simultaneous irqack
    pin_i = 4'b0110;
    @(negedge cp2);
    @(negedge cp2);
    irqack = 1'b1;
    @(negedge cp2);
    irqack = 1'b0;
    #1; check_value("coinc_ack", 32'(irq_o), 1);
    @(negedge cp2);
    irqack = 1'b1;
    @(negedge cp2);
    irqack = 1'b0;
    #1; check_value("ack_clear", 32'(irq_o), 0);

    // pcie_i masks irq_o but keeps the flag; async reset mid-operation
    pin_i = 4'b0010; repeat (3) @(negedge cp2);
    #1; check_value("pre_pcie", 32'(irq_o), 1);
    pcie_i = 1'b0;
    #1; check_value("pcie_off_irq", 32'(irq_o), 0);
    read_pcifr("pcie_off_flag", 8'h08);
    pcie_i = 1'b1;
    #1; check_value("pcie_on_irq", 32'(irq_o), 1);
    #2; ireset = 1'b0;
    #1; check_value("async_rst_irq", 32'(irq_o), 0);
    check_value("async_rst_mask", 32'(pcmsk_o), 0);
    @(negedge cp2);
    ireset = 1'b1;
    #1; check_value("post_rst_irq", 32'(irq_o), 0);
    read_pcmsk("post_rst_mask", 8'h00);

    // Bits above WIDTH are dropped
    mask_write(8'hF5);
    check_value("mask_trunc", 32'(pcmsk_o), 32'h5);
    read_pcmsk("rd_trunc", 8'h05);

    // Wake path with cp2 stopped
    mask_write(8'h01);
    SLEEP = 1'b1;
    repeat (3) @(negedge cp2);
    #1; check_value("wake_idle", 32'(wake_o), 0);
    @(negedge cp2);
    clk_en = 1'b0;
    #2;
    pin_i = 4'b0011;
    #1;
`ifdef PCINT_WAKE_EN
    check_value("wake_stopped", 32'(wake_o), 1);
`else
    check_value("wake_stopped", 32'(wake_o), 0);
`endif
    #20;
    check_value("irq_stopped", 32'(irq_o), 0);
    clk_en = 1'b1;
    repeat (3) @(negedge cp2);
    #1;
    check_value("irq_resume", 32'(irq_o), 1);
    check_value("wake_resume", 32'(wake_o), 0);
    SLEEP = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcint_group_ctrl.md
Name: pcint_group_ctrl

Overview:
- Pin-change interrupt group for one GPIO port slice. Default configuration is Port E, PCINT[27:24], group 3.
- Synchronises raw pad inputs, detects edges on masked pins, holds the group flag (PCIFn) and raises the interrupt request to the core's vector logic.
- Owns the PCMSKn register (data-space mapped) and the PCIFn bit of PCIFR (IO-space mapped).
- Exports the mask to the port block, which combines it with PCIEn to override digital input enables.

Parameters:
- WIDTH, 4, number of pins in the group.
- PCMSK_ADDRESS, 8'h73, data-space address of PCMSKn.
- PCIFR_ADDRESS, 6'h1B, IO-space address of PCIFR.
- PCIF_BIT, 3, bit position of PCIFn within PCIFR.

Ports:
- cp2  in  1  system clock.
- ireset  in  1  asynchronous, active-low reset.
- IO_Addr  in  6  IO-space address.
- iore  in  1  IO read strobe.
- iowe  in  1  IO write strobe.
- ramadr  in  8  data-space address, low byte.
- ramre  in  1  data-space read strobe.
- ramwe  in  1  data-space write strobe.
- dbus_in  in  8  write data.
- dbus_out  out  8  read data.
- out_en  out  1  read-data valid for the bus mux.
- pin_i  in  WIDTH  raw pad values (same pins that feed the port's PINx).
- pcie_i  in  1  PCIEn bit from PCICR.
- SLEEP  in  1  core in sleep mode.
- irqack  in  1  core acknowledging this vector.
- pcmsk_o  out  WIDTH  current PCMSKn, to the port's PCINT input.
- irq_o  out  1  interrupt request.
- wake_o  out  1  asynchronous wake request.

Behaviour:
- Reset (ireset=0, async): sync1, sync2, prev, pcmsk, pcif all 0. Outputs: irq_o=0, wake_o=0, out_en=0, dbus_out=0, pcmsk_o=0.
- Synchroniser: sync1<=pin_i, sync2<=sync1, prev<=sync2, every cp2 edge.
  - prev updates regardless of mask or pcie_i, so enabling a mask bit never produces a spurious flag from stale history.
- Change detect: chg = |((sync2 ^ prev) & pcmsk) & pcie_i.
- Latency: a pad change sampled at edge N sets pcif at edge N+2. irq_o is asserted from that edge.
- Flag register pcif:
  - Set when chg=1.
  - Cleared when iowe=1, IO_Addr==PCIFR_ADDRESS and dbus_in[PCIF_BIT]=1 (write-one-to-clear; writing 0 has no effect).
  - Cleared when irqack=1.
  - Set wins over any simultaneous clear, so no edge is lost.
- irq_o = pcif & pcie_i. Clearing pcie_i masks irq_o but keeps pcif.
- PCMSK write: ramwe=1 and ramadr==PCMSK_ADDRESS -> pcmsk<=dbus_in[WIDTH-1:0]. Bits above WIDTH are ignored.
- Reads (combinational, same cycle):
  - iore & IO_Addr==PCIFR_ADDRESS -> out_en=1; dbus_out has pcif at PCIF_BIT, all other bits 0 (the bus ORs the other groups' bits).
  - ramre & ramadr==PCMSK_ADDRESS -> out_en=1; dbus_out={0, pcmsk}.
  - Otherwise out_en=0, dbus_out=0.
- pcmsk_o = pcmsk, continuously.
- Reset mid-operation: flags and history are lost; any pending irq_o drops immediately, asynchronously.
- Toggles faster than 2 cycles: intermediate edges may merge into one flag. The flag is a single bit; multiple changes before clear produce one interrupt.

Optional Feature:
- Macro: PCINT_WAKE_EN.
- Defined: wake_o = SLEEP & pcie_i & |((pin_i ^ prev) & pcmsk). This is combinational from the raw pad, so it works with cp2 stopped in power-down. pcif is set normally once cp2 resumes.
- Undefined: wake_o tied to 0; no combinational pad path.

Test Plan:
- Reset, then write PCMSK=4'b0100 and pcie_i=1; pin_i 0000->0100 at edge N -> pcif=1 and irq_o=1 at edge N+2; PCMSK read returns 8'h04 with out_en=1.
- Mask=0, toggle pin_i[2] several times, then set mask=4'b0100 with no further pin changes -> pcif stays 0; a later toggle on pin 1 -> no flag.
- pcif=1; write PCIFR with 8'h08 -> pcif=0 next edge. Write 8'h00 instead -> pcif stays 1. Read PCIFR returns 8'h08 while set.
- Detect cycle coincides with a W1C write (or irqack) -> pcif remains 1 and irq_o stays high.
- pcif=1, pcie_i->0 -> irq_o=0, pcif read still 1. Assert ireset mid-operation -> irq_o=0 asynchronously, and pcmsk=0 after release.
- With PCINT_WAKE_EN defined: SLEEP=1, mask=4'b0001, pcie_i=1, cp2 stopped, pin_i[0] 0->1 -> wake_o=1 immediately. Without the macro -> wake_o=0.
